// File: rtl/retire_trace_sync_pkg.sv
// Shared widths and reset constants for the retirement trace tracker.
package retire_trace_sync_pkg;

  localparam int unsigned PC_W_DEF   = 32;
  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 32;
  localparam int unsigned BE_W       = 4;

  // Slot valid after reset; in-flight instructions are dropped, never committed.
  localparam logic SLOT_RST_VALID = 1'b0;

endpackage

// File: rtl/retire_slot.sv
// One pipeline stage register of the retirement tracker: holds on stall,
// and zeroes the store attributes whenever the incoming slot is a bubble.
module retire_slot
  import retire_trace_sync_pkg::*;
#(
  parameter int unsigned PC_W   = PC_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              in_valid,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_store,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [BE_W-1:0]   in_be,
  output logic              out_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_store,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [BE_W-1:0]   out_be
);

  logic              valid_q, valid_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              store_q, store_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [BE_W-1:0]   be_q, be_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    store_d = store_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    if (!hold) begin
      valid_d = in_valid;
      pc_d    = in_pc;
      store_d = in_valid & in_store;
      addr_d  = in_valid ? in_addr : '0;
      data_d  = in_valid ? in_data : '0;
      be_d    = in_valid ? in_be   : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= SLOT_RST_VALID;
      pc_q    <= '0;
      store_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      store_q <= store_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
    end
  end

  assign out_valid = valid_q;
  assign out_pc    = pc_q;
  assign out_store = store_q;
  assign out_addr  = addr_q;
  assign out_data  = data_q;
  assign out_be    = be_q;

endmodule

// File: rtl/retire_trace_sync.sv
// Retirement tracker: shadows ID->EX->MEM->WB and pulses a commit record one
// cycle after the WB register-file write, for the lockstep checker.
module retire_trace_sync
  import retire_trace_sync_pkg::*;
#(
  parameter int unsigned PC_W   = PC_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [PC_W-1:0]   id_pc,
  input  logic              flush_id,
  input  logic              stall,
  input  logic              ex_store,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [BE_W-1:0]   ex_be,
  output logic              check_en,
  output logic [PC_W-1:0]   check_pc,
  output logic              check_store,
  output logic [ADDR_W-1:0] check_addr,
  output logic [DATA_W-1:0] check_data,
  output logic [BE_W-1:0]   check_be,
  output logic [CNT_W-1:0]  retire_cnt
);

  logic              ex_valid, mem_valid, wb_valid;
  logic [PC_W-1:0]   ex_pc, mem_pc, wb_pc;
  logic              ex_st, mem_st, wb_st;
  logic [ADDR_W-1:0] ex_ad, mem_ad, wb_ad;
  logic [DATA_W-1:0] ex_dt, mem_dt, wb_dt;
  logic [BE_W-1:0]   ex_bs, mem_bs, wb_bs;

  // The EX slot only tracks valid/pc; store attributes join at the EX->MEM edge.
  logic unused_ex_attr;
  assign unused_ex_attr = ^{ex_st, ex_ad, ex_dt, ex_bs};

  retire_slot #(.PC_W(PC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ex (
    .clk(clk), .rst_n(rst_n), .hold(stall),
    .in_valid(id_valid & ~flush_id), .in_pc(id_pc),
    .in_store(1'b0), .in_addr('0), .in_data('0), .in_be('0),
    .out_valid(ex_valid), .out_pc(ex_pc), .out_store(ex_st),
    .out_addr(ex_ad), .out_data(ex_dt), .out_be(ex_bs)
  );

  retire_slot #(.PC_W(PC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
    .clk(clk), .rst_n(rst_n), .hold(stall),
    .in_valid(ex_valid), .in_pc(ex_pc),
    .in_store(ex_store), .in_addr(ex_addr), .in_data(ex_wdata), .in_be(ex_be),
    .out_valid(mem_valid), .out_pc(mem_pc), .out_store(mem_st),
    .out_addr(mem_ad), .out_data(mem_dt), .out_be(mem_bs)
  );

  retire_slot #(.PC_W(PC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wb (
    .clk(clk), .rst_n(rst_n), .hold(stall),
    .in_valid(mem_valid), .in_pc(mem_pc),
    .in_store(mem_st), .in_addr(mem_ad), .in_data(mem_dt), .in_be(mem_bs),
    .out_valid(wb_valid), .out_pc(wb_pc), .out_store(wb_st),
    .out_addr(wb_ad), .out_data(wb_dt), .out_be(wb_bs)
  );

  logic              commit;
  logic              check_en_q, check_en_d;
  logic [PC_W-1:0]   check_pc_q, check_pc_d;
  logic              check_store_q, check_store_d;
  logic [ADDR_W-1:0] check_addr_q, check_addr_d;
  logic [DATA_W-1:0] check_data_q, check_data_d;
  logic [BE_W-1:0]   check_be_q, check_be_d;
  logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;

  // Commit on the edge WB is vacated, so a stalled WB instruction fires once.
  assign commit = wb_valid & ~stall;

  always_comb begin
    check_en_d    = commit;
    check_pc_d    = check_pc_q;
    check_store_d = 1'b0;
    check_addr_d  = check_addr_q;
    check_data_d  = check_data_q;
    check_be_d    = check_be_q;
    retire_cnt_d  = retire_cnt_q;
    if (commit) begin
      check_pc_d    = wb_pc;
      check_store_d = wb_st;
      check_addr_d  = wb_ad;
      check_data_d  = wb_dt;
      check_be_d    = wb_bs;
      retire_cnt_d  = retire_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      check_en_q    <= 1'b0;
      check_pc_q    <= '0;
      check_store_q <= 1'b0;
      check_addr_q  <= '0;
      check_data_q  <= '0;
      check_be_q    <= '0;
      retire_cnt_q  <= '0;
    end else begin
      check_en_q    <= check_en_d;
      check_pc_q    <= check_pc_d;
      check_store_q <= check_store_d;
      check_addr_q  <= check_addr_d;
      check_data_q  <= check_data_d;
      check_be_q    <= check_be_d;
      retire_cnt_q  <= retire_cnt_d;
    end
  end

  assign check_en    = check_en_q;
  assign check_pc    = check_pc_q;
  assign check_store = check_store_q;
  assign check_addr  = check_addr_q;
  assign check_data  = check_data_q;
  assign check_be    = check_be_q;
  assign retire_cnt  = retire_cnt_q;

endmodule

// File: tb/tb_retire_trace_sync.sv
// Scoreboard bench for retire_trace_sync: an edge-counting reference model
// predicts each commit record and the edge it appears on.
module tb_retire_trace_sync;

  localparam int unsigned CW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_pc = '0;
  logic        flush_id = 1'b0;
  logic        stall = 1'b0;
  logic        ex_store = 1'b0;
  logic [31:0] ex_addr = '0;
  logic [31:0] ex_wdata = '0;
  logic [3:0]  ex_be = '0;
  logic        check_en;
  logic [31:0] check_pc;
  logic        check_store;
  logic [31:0] check_addr;
  logic [31:0] check_data;
  logic [3:0]  check_be;
  logic [CW-1:0] retire_cnt;

  retire_trace_sync #(.PC_W(32), .ADDR_W(32), .DATA_W(32), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .flush_id(flush_id), .stall(stall), .ex_store(ex_store),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_be(ex_be),
    .check_en(check_en), .check_pc(check_pc), .check_store(check_store),
    .check_addr(check_addr), .check_data(check_data), .check_be(check_be),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        st;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int unsigned cap;
    int unsigned due;
  } ent_t;

  ent_t        inflight[$];
  ent_t        sb[$];
  int unsigned edge_no = 0;
  int unsigned nse = 0;
  int unsigned exp_cnt = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          ex_has = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: an instruction accepted on advancing edge k takes its
  // store attributes on advancing edge k+1 and commits on advancing edge k+3.
  initial begin
    ent_t e;
    forever begin
      @(posedge clk);
      edge_no++;
      if (!rst_n) begin
        inflight.delete();
        nse = 0;
      end else if (!stall) begin
        nse++;
        if (inflight.size() > 0 && inflight[0].cap + 3 == nse) begin
          e = inflight.pop_front();
          e.due = edge_no;
          sb.push_back(e);
        end
        foreach (inflight[i]) begin
          if (inflight[i].cap + 1 == nse) begin
            inflight[i].st   = ex_store;
            inflight[i].addr = ex_addr;
            inflight[i].data = ex_wdata;
            inflight[i].be   = ex_be;
          end
        end
        if (id_valid && !flush_id) begin
          e.pc = id_pc; e.st = 1'b0; e.addr = '0; e.data = '0; e.be = '0;
          e.cap = nse; e.due = 0;
          inflight.push_back(e);
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT pulses check_en.
  initial begin
    ent_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        sb.delete();
        exp_cnt = 0;
      end else begin
        if (check_en) begin
          if (sb.size() == 0) begin
            chk("commit_en_spurious", 64'(check_en), 64'(0));
          end else begin
            e = sb.pop_front();
            chk("commit_edge", 64'(edge_no), 64'(e.due));
            chk("check_pc", 64'(check_pc), 64'(e.pc));
            chk("check_store", 64'(check_store), 64'(e.st));
            chk("check_addr", 64'(check_addr), 64'(e.addr));
            chk("check_data", 64'(check_data), 64'(e.data));
            chk("check_be", 64'(check_be), 64'(e.be));
            exp_cnt++;
          end
        end else begin
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("commit_en_missing", 64'(check_en), 64'(1));
          end
          chk("store_idle", 64'(check_store), 64'(0));
        end
        chk("retire_cnt", 64'(retire_cnt), 64'(exp_cnt % (1 << CW)));
      end
    end
  end

  task automatic cyc_ex(input logic v, input logic [31:0] pc, input logic f, input logic s,
                        input logic st, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be);
    id_valid = v; id_pc = pc; flush_id = f; stall = s;
    ex_store = st; ex_addr = a; ex_wdata = d; ex_be = be;
    @(posedge clk);
    if (!s) ex_has = v & ~f;
    @(negedge clk);
  endtask

  // With a real instruction in EX, non-stores carry zero attributes; a bubble
  // in EX gets garbage so the bubble gating is exercised.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic f, input logic s);
    logic st;
    st = 1'($urandom % 2);
    if (ex_has && !st)
      cyc_ex(v, pc, f, s, 1'b0, '0, '0, '0);
    else
      cyc_ex(v, pc, f, s, st, $urandom, $urandom, 4'($urandom));
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(1'b0, $urandom, 1'b0, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_en"}, 64'(check_en), 64'(0));
    chk({tag, "_pc"}, 64'(check_pc), 64'(0));
    chk({tag, "_store"}, 64'(check_store), 64'(0));
    chk({tag, "_addr"}, 64'(check_addr), 64'(0));
    chk({tag, "_data"}, 64'(check_data), 64'(0));
    chk({tag, "_be"}, 64'(check_be), 64'(0));
    chk({tag, "_cnt"}, 64'(retire_cnt), 64'(0));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    cyc(1'b1, 32'hBFC0_0000, 1'b0, 1'b0);
    idle(5);

    cyc(1'b1, 32'h0040_0010, 1'b0, 1'b0);
    cyc_ex(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF);
    idle(5);

    cyc(1'b1, 32'h0040_0014, 1'b0, 1'b0);
    idle(2);
    for (int unsigned i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1);
    idle(5);

    cyc(1'b1, 32'h0040_0020, 1'b1, 1'b0);
    cyc(1'b1, 32'h0040_0024, 1'b0, 1'b0);
    idle(5);

    cyc(1'b1, 32'h0040_0030, 1'b1, 1'b1);
    cyc(1'b1, 32'h0040_0030, 1'b0, 1'b0);
    idle(5);

    cyc(1'b1, 32'h0040_0040, 1'b0, 1'b0);
    cyc(1'b1, 32'h0040_0044, 1'b0, 1'b0);
    cyc(1'b1, 32'h0040_0048, 1'b0, 1'b0);
    id_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ex_has = 1'b0;
    idle(6);

    for (int unsigned i = 0; i < 400; i++)
      cyc(1'($urandom % 4 != 0), $urandom, 1'($urandom % 4 == 0), 1'($urandom % 4 == 0));
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/retire_trace_sync.md
Name: retire_trace_sync

Overview:
- Pipeline-aligned retirement tracker inside the Processor hierarchy, instantiated as Test_Sync.
- Follows each instruction from ID through EX, MEM and WB, carrying its PC and store attributes alongside it.
- Emits a one-cycle commit pulse with PC, store address and store data once the instruction's register-file write is architecturally visible.
- Directly feeds the two-model lockstep checker.

Parameters:
- PC_W, 32, width of program counter.
- ADDR_W, 32, width of store virtual address.
- DATA_W, 32, width of store data.
- CNT_W, 32, width of retire counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  non-bubble instruction present in ID.
- id_pc  in  PC_W  PC of instruction in ID.
- flush_id  in  1  squash instruction in ID (it enters EX as bubble).
- stall  in  1  global pipeline freeze; ID, EX, MEM and WB all hold.
- ex_store  in  1  instruction in EX is SB/SH/SW.
- ex_addr  in  ADDR_W  effective address computed in EX.
- ex_wdata  in  DATA_W  store data in EX, unmasked, lane-aligned.
- ex_be  in  4  byte enables for the store.
- check_en  out  1  commit pulse.
- check_pc  out  PC_W  PC of committing instruction.
- check_store  out  1  committing instruction was a store.
- check_addr  out  ADDR_W  store address, 0 if not a store.
- check_data  out  DATA_W  raw store data, 0 if not a store.
- check_be  out  4  store byte enables, 0 if not a store.
- retire_cnt  out  CNT_W  number of committed instructions.

Behaviour:
- Reset (rst_n low, asynchronous): all slot valids = 0, all outputs = 0, retire_cnt = 0. Reset takes effect immediately, mid-pipeline included. In-flight instructions are discarded and never commit.
- Slots: EX, MEM and WB registers, each holding valid, pc, store, addr, data and be.
- Advance when stall = 0:
  - EX <= {id_valid & ~flush_id, id_pc}.
  - MEM <= EX, with store, addr, data and be taken from the ex_* inputs, gated by EX.valid. If EX.valid = 0, store = 0 and addr/data/be = 0.
  - WB <= MEM.
- When stall = 1, all slots hold. flush_id is ignored during stall, so the squashing logic must hold flush_id until stall deasserts.
- Commit event: WB.valid & ~stall at a rising edge. On the following cycle:
  - check_en = 1 for exactly one cycle.
  - check_pc and check_store/addr/data/be = WB contents.
  - retire_cnt increments by 1, wrapping modulo 2^CNT_W.
- With no commit, check_en = 0. check_pc/addr/data/be keep their last values; check_store is cleared to 0.
- Latency: an instruction in ID at edge n with no stalls and no flush produces check_en high in cycle n+4. This is one cycle after its WB register write, so the register file already holds the result when the checker samples it at the falling edge.
- Stall of k cycles anywhere adds exactly k cycles of latency. An instruction stuck in WB commits once, when it leaves, never repeatedly.
- Branch delay slots are ordinary valid instructions and commit. Squashed or bubble slots never commit.
- Back-to-back: one commit per cycle maximum; check_en may stay high for consecutive cycles.
- Width rules: no arithmetic except retire_cnt; all fields are passed through unmodified. Masking of halfword/byte data is the consumer's job.

Decomposition:
- Shared package/defines file (alongside MIPS1000_defines.v): PC_W/ADDR_W/DATA_W defaults and a reset-value constant for slot contents.
- One sub-module is natural: retire_slot, a single stage register with hold and valid-gating, instantiated three times for EX, MEM and WB. Counter and output register stay in the top.

Test Plan:
- Reset then id_valid=1, id_pc=0xBFC00000, no stall → check_en high exactly in cycle 4 after capture, check_pc=0xBFC00000, check_store=0, retire_cnt=1.
- Store: id_pc=0x00400010, one cycle later ex_store=1, ex_addr=0x10000004, ex_wdata=0xDEADBEEF, ex_be=4'b1111 → commit with check_addr=0x10000004, check_data=0xDEADBEEF, check_be=4'hF, check_store=1.
- Stall: stall=1 for 3 cycles while an instruction sits in WB → exactly one check_en pulse, delayed by 3 cycles; retire_cnt advances by 1.
- Flush: id_pc=0x00400020 with flush_id=1, followed by id_pc=0x00400024 unflushed → only 0x00400024 commits, retire_cnt +1.
- Simultaneous stall=1 and flush_id=1 for one cycle, flush dropped with stall → the instruction is not squashed and commits normally.
- Reset mid-run: 3 instructions in flight, pull rst_n low asynchronously between edges → outputs and counter 0 immediately, no commit pulse for discarded instructions after release.
